requant_output_stage: RTL and testbench
=======================================

Name: requant_output_stage

Overview:
- Downstream consumer of the eight_x_eight systolic array's output-buffer read port.
- Takes one 8-lane row of signed ACC_WIDTH accumulators per accepted beat and requantizes it to signed DATA_WIDTH: fixed-point multiply, rounding right shift, zero-point add, optional ReLU clamp, saturation.
- Emits rows over a valid/ready stream toward the activation memory or the next layer's input loader.
- Tracks 8-row tile boundaries and flags the last row of each tile.

Parameters:
- DATA_WIDTH, 8, output element width (signed).
- ACC_WIDTH, 32, input accumulator width (signed).
- SCALE_WIDTH, 16, signed requant multiplier width.
- LANES, 8, elements per row (matches array dimension).
- TILE_ROWS, 8, rows per tile.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk).
- in_valid  in  1  c_in row valid.
- in_ready  out  1  stage accepts a row this cycle.
- c_in[LANES]  in  ACC_WIDTH signed  accumulator row from array output buffer.
- scale  in  SCALE_WIDTH signed  requant multiplier.
- shift  in  6  arithmetic right-shift amount, 0..47.
- zero_point  in  DATA_WIDTH signed  output zero point.
- relu_en  in  1  clamp lower bound to zero_point.
- out_valid  out  1  q_out row valid.
- out_ready  in  1  downstream accepts.
- q_out[LANES]  out  DATA_WIDTH signed  requantized row.
- out_last  out  1  q_out is row TILE_ROWS-1 of its tile.

Behaviour:
- Reset (rst=0 at posedge): all pipeline valids = 0, out_valid = 0, q_out = 0, out_last = 0, row counter = 0, config registers = 0. Applies mid-stream: in-flight rows are discarded, not drained.
- Pipeline: 3 stages, S1 multiply, S2 round/shift/zero-point, S3 clamp → output registers. Latency: 3 cycles from accepted input to out_valid.
- advance = !out_valid || out_ready. All stages shift together on advance; stalls globally otherwise.
- in_ready = advance. A row is accepted when in_valid && in_ready.
- Output is held stable (q_out, out_last) while out_valid && !out_ready. No bubbles are inserted while in_valid stays high and out_ready stays high: throughput is 1 row/cycle.
- Config latching: scale, shift, zero_point, relu_en are captured on acceptance of row 0 of a tile and used for all 8 rows of that tile. Mid-tile config changes are ignored until the next tile.
- Row counter: increments on each accept and wraps TILE_ROWS-1 → 0. Its value travels with the data; out_last = 1 with the row whose counter was TILE_ROWS-1.
- Arithmetic, per lane:
  - prod = c_in * scale, full ACC_WIDTH+SCALE_WIDTH signed (48 bits), no truncation.
  - shift == 0: r = prod. Otherwise r = (prod + 2^(shift-1)) >>> shift (round-half-up toward +inf, arithmetic shift).
  - v = r + zero_point, evaluated in 49 bits.
  - lo = relu_en ? zero_point : -2^(DATA_WIDTH-1); hi = 2^(DATA_WIDTH-1)-1.
  - q = clamp(v, lo, hi).
- shift values > 47 are treated as 47.
- Simultaneous accept and output handshake in the same cycle is legal and required: pipeline advances, no data loss.

Optional Feature:
- Macro REQUANT_BIAS_EN.
- Defined: adds input port bias[LANES], ACC_WIDTH signed, latched with the config at tile start. bias[i] is added to c_in[i] before the multiply (sum saturated to ACC_WIDTH). Latency unchanged: the add is folded into S1.
- Undefined: no bias port; c_in is multiplied directly.

Decomposition:
- Shared package (systolic_pkg): DATA_WIDTH/ACC_WIDTH defaults, the acc_row_t and q_row_t LANES-wide array typedefs, the requant_cfg_t struct (scale, shift, zero_point, relu_en), and the QMIN/QMAX constants.
- One sub-module, requant_lane: combinational per-stage math for a single element, instantiated LANES times. Pipeline registers, handshake and the row counter stay in the top.

Test Plan:
- scale=1, shift=0, zp=0, relu=0; rows of c_in = 100, 300, -300, 0 → q = 100, 127, -128, 0, out_valid exactly 3 cycles after each accept.
- scale=3, shift=2, zp=0; c_in = 10, 9, -10 → 30/4 = 7.5 → 8; 27/4 = 6.75 → 7; -30/4 = -7.5 → -7.
- relu=1, zp=5, scale=1, shift=0; c_in = -5, 3, 200 → 5, 8, 127.
- Back-to-back 16 rows with out_ready=1 → 16 outputs on consecutive cycles; out_last on rows 7 and 15 only. Config changed at row 4 takes effect only from row 8.
- out_ready held 0 for 5 cycles mid-stream → in_ready drops within the same cycle, q_out stable, no row lost or duplicated after release.
- rst=0 for one cycle with 3 rows in flight → out_valid=0 next cycle; following rows start a fresh tile (out_last on the 8th new row).

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared widths, row types and requant config for the systolic array output path.
package systolic_pkg;
  localparam int DATA_WIDTH  = 8;
  localparam int ACC_WIDTH   = 32;
  localparam int SCALE_WIDTH = 16;
  localparam int LANES       = 8;
  localparam int TILE_ROWS   = 8;
  localparam int PROD_W      = ACC_WIDTH + SCALE_WIDTH;
  localparam logic [5:0] SHIFT_MAX = 6'd47;

  typedef logic signed [ACC_WIDTH-1:0]  acc_t;
  typedef logic signed [DATA_WIDTH-1:0] q_t;
  typedef acc_t [LANES-1:0] acc_row_t;
  typedef q_t   [LANES-1:0] q_row_t;

  localparam q_t QMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam q_t QMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  typedef struct packed {
    logic signed [SCALE_WIDTH-1:0] scale;
    logic [5:0]                    shift;
    q_t                            zero_point;
    logic                          relu_en;
  } requant_cfg_t;
endpackage

// File: rtl/requant_output_stage_if.sv
// Input accumulator stream and output quantized stream of the requant stage.
interface requant_output_stage_if;
  import systolic_pkg::*;
  logic     in_valid;
  logic     in_ready;
  acc_row_t c_in;
  logic     out_valid;
  logic     out_ready;
  q_row_t   q_out;
  logic     out_last;

  modport master (output in_valid, c_in, out_ready,
                  input  in_ready, out_valid, q_out, out_last);
  modport slave  (input  in_valid, c_in, out_ready,
                  output in_ready, out_valid, q_out, out_last);
endinterface

// File: rtl/requant_output_stage_lane.sv
// Per-element combinational math for each requant pipeline stage.
// REQUANT_BIAS_EN folds a saturating bias add ahead of the multiply.
module requant_lane import systolic_pkg::*; (
  input  acc_t                      c_in,
`ifdef REQUANT_BIAS_EN
  input  acc_t                      bias,
`endif
  input  logic signed [SCALE_WIDTH-1:0] scale,
  output logic signed [PROD_W-1:0]  prod,
  input  logic signed [PROD_W-1:0]  prod_in,
  input  logic [5:0]                shift,
  input  q_t                        zp_s2,
  output logic signed [PROD_W:0]    v,
  input  logic signed [PROD_W:0]    v_in,
  input  logic                      relu_en,
  input  q_t                        zp_s3,
  output q_t                        q
);
  acc_t                    a;
  logic [5:0]              sh;
  logic signed [PROD_W:0]  rnd, lo, hi;
`ifdef REQUANT_BIAS_EN
  logic signed [ACC_WIDTH:0] sum;
`endif

  always_comb begin
`ifdef REQUANT_BIAS_EN
    sum = (ACC_WIDTH+1)'(c_in) + (ACC_WIDTH+1)'(bias);
    if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1])
      a = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    else
      a = sum[ACC_WIDTH-1:0];
`else
    a = c_in;
`endif
    prod = PROD_W'(a) * PROD_W'(scale);
  end

  // 49-bit headroom keeps the rounding add exact for the largest product.
  always_comb begin
    sh  = (shift > SHIFT_MAX) ? SHIFT_MAX : shift;
    rnd = '0;
    if (sh != 6'd0) rnd = (PROD_W+1)'(1) <<< (sh - 6'd1);
    v = (((PROD_W+1)'(prod_in) + rnd) >>> sh) + (PROD_W+1)'(zp_s2);
  end

  always_comb begin
    lo = relu_en ? (PROD_W+1)'(zp_s3) : (PROD_W+1)'(QMIN);
    hi = (PROD_W+1)'(QMAX);
    if (v_in < lo)      q = lo[DATA_WIDTH-1:0];
    else if (v_in > hi) q = hi[DATA_WIDTH-1:0];
    else                q = v_in[DATA_WIDTH-1:0];
  end
endmodule

// File: rtl/requant_output_stage.sv
// 3-stage requantizer (multiply, round/shift/zp, clamp) with tile-latched config.
// REQUANT_BIAS_EN adds a per-lane bias input latched alongside the config.
module requant_output_stage import systolic_pkg::*; (
  input  logic                          clk,
  input  logic                          rst,
  requant_output_stage_if.slave         io,
  input  logic signed [SCALE_WIDTH-1:0] scale,
  input  logic [5:0]                    shift,
  input  q_t                            zero_point,
  input  logic                          relu_en
`ifdef REQUANT_BIAS_EN
  ,input acc_row_t                      bias
`endif
);
  localparam int STAGES = 3;
  localparam int CNT_W  = $clog2(TILE_ROWS);

  logic [STAGES:1] vld_pipe_q, vld_pipe_d;
  logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
  requant_cfg_t cfg_q, cfg_d, cfg_live, cfg_eff;
  logic signed [LANES-1:0][PROD_W-1:0] s1_prod_q, s1_prod_d, prod_w;
  logic [5:0] s1_shift_q, s1_shift_d;
  q_t   s1_zp_q, s1_zp_d, s2_zp_q, s2_zp_d;
  logic s1_relu_q, s1_relu_d, s2_relu_q, s2_relu_d;
  logic s1_last_q, s1_last_d, s2_last_q, s2_last_d, last_q, last_d;
  logic signed [LANES-1:0][PROD_W:0] s2_v_q, s2_v_d, v_w;
  q_row_t q_out_q, q_out_d, q_w;
  logic advance, accept, tile_start;
`ifdef REQUANT_BIAS_EN
  acc_row_t bias_q, bias_d, bias_eff;
`endif

  assign advance    = !vld_pipe_q[STAGES] || io.out_ready;
  assign accept     = io.in_valid && advance;
  assign tile_start = (row_cnt_q == '0);
  assign cfg_live   = '{scale: scale, shift: shift, zero_point: zero_point, relu_en: relu_en};
  // Row 0 of a tile sees the live config; the rest reuse what it latched.
  assign cfg_eff    = tile_start ? cfg_live : cfg_q;
`ifdef REQUANT_BIAS_EN
  assign bias_eff   = tile_start ? bias : bias_q;
`endif

  assign io.in_ready  = advance;
  assign io.out_valid = vld_pipe_q[STAGES];
  assign io.q_out     = q_out_q;
  assign io.out_last  = last_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    requant_lane u_lane (
      .c_in    (io.c_in[i]),
`ifdef REQUANT_BIAS_EN
      .bias    (bias_eff[i]),
`endif
      .scale   (cfg_eff.scale),
      .prod    (prod_w[i]),
      .prod_in (s1_prod_q[i]),
      .shift   (s1_shift_q),
      .zp_s2   (s1_zp_q),
      .v       (v_w[i]),
      .v_in    (s2_v_q[i]),
      .relu_en (s2_relu_q),
      .zp_s3   (s2_zp_q),
      .q       (q_w[i])
    );
  end

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    row_cnt_d  = row_cnt_q;
    cfg_d      = cfg_q;
    s1_prod_d  = s1_prod_q;  s1_shift_d = s1_shift_q; s1_zp_d = s1_zp_q;
    s1_relu_d  = s1_relu_q;  s1_last_d  = s1_last_q;
    s2_v_d     = s2_v_q;     s2_zp_d    = s2_zp_q;    s2_relu_d = s2_relu_q;
    s2_last_d  = s2_last_q;
    q_out_d    = q_out_q;    last_d     = last_q;
`ifdef REQUANT_BIAS_EN
    bias_d     = bias_q;
`endif
    if (advance) begin
      vld_pipe_d = {vld_pipe_q[STAGES-1:1], io.in_valid};
      s1_prod_d  = prod_w;
      s1_shift_d = cfg_eff.shift;
      s1_zp_d    = cfg_eff.zero_point;
      s1_relu_d  = cfg_eff.relu_en;
      s1_last_d  = accept && (row_cnt_q == CNT_W'(TILE_ROWS-1));
      s2_v_d     = v_w;
      s2_zp_d    = s1_zp_q;
      s2_relu_d  = s1_relu_q;
      s2_last_d  = s1_last_q;
      q_out_d    = q_w;
      last_d     = s2_last_q;
    end
    if (accept) begin
      row_cnt_d = (row_cnt_q == CNT_W'(TILE_ROWS-1)) ? '0 : row_cnt_q + CNT_W'(1);
      if (tile_start) begin
        cfg_d = cfg_live;
`ifdef REQUANT_BIAS_EN
        bias_d = bias;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_pipe_q <= '0; row_cnt_q <= '0; cfg_q <= '0;
      s1_prod_q <= '0; s1_shift_q <= '0; s1_zp_q <= '0; s1_relu_q <= 1'b0; s1_last_q <= 1'b0;
      s2_v_q <= '0; s2_zp_q <= '0; s2_relu_q <= 1'b0; s2_last_q <= 1'b0;
      q_out_q <= '0; last_q <= 1'b0;
`ifdef REQUANT_BIAS_EN
      bias_q <= '0;
`endif
    end else begin
      vld_pipe_q <= vld_pipe_d; row_cnt_q <= row_cnt_d; cfg_q <= cfg_d;
      s1_prod_q <= s1_prod_d; s1_shift_q <= s1_shift_d; s1_zp_q <= s1_zp_d;
      s1_relu_q <= s1_relu_d; s1_last_q <= s1_last_d;
      s2_v_q <= s2_v_d; s2_zp_q <= s2_zp_d; s2_relu_q <= s2_relu_d; s2_last_q <= s2_last_d;
      q_out_q <= q_out_d; last_q <= last_d;
`ifdef REQUANT_BIAS_EN
      bias_q <= bias_d;
`endif
    end
  end
endmodule

// File: tb/tb_requant_output_stage.sv
// Directed checks of requant_output_stage: arithmetic, latency, tiles, stalls, reset.
module tb_requant_output_stage;
  import systolic_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic signed [SCALE_WIDTH-1:0] scale = '0;
  logic [5:0] shift = '0;
  q_t   zero_point = '0;
  logic relu_en = 1'b0;
  int   total = 0;
  int   bad = 0;
`ifdef REQUANT_BIAS_EN
  acc_row_t bias = '0;
`endif

  requant_output_stage_if io();

  requant_output_stage dut (
    .clk(clk), .rst(rst), .io(io),
    .scale(scale), .shift(shift), .zero_point(zero_point), .relu_en(relu_en)
`ifdef REQUANT_BIAS_EN
    ,.bias(bias)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; io.in_valid = 1'b0; io.out_ready = 1'b1;
    step();
    rst = 1'b1;
  endtask

  function automatic acc_row_t mk_acc(input int a0, a1, a2, a3, a4, a5, a6, a7);
    acc_row_t r;
    r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3; r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
    return r;
  endfunction

  function automatic q_row_t mk_q(input int a0, a1, a2, a3, a4, a5, a6, a7);
    q_row_t r;
    r[0] = 8'(a0); r[1] = 8'(a1); r[2] = 8'(a2); r[3] = 8'(a3);
    r[4] = 8'(a4); r[5] = 8'(a5); r[6] = 8'(a6); r[7] = 8'(a7);
    return r;
  endfunction

  function automatic acc_row_t seq_acc(input int k, input int mul, input int stride);
    acc_row_t r;
    for (int i = 0; i < LANES; i++) r[i] = 32'(k * mul + i * stride);
    return r;
  endfunction

  function automatic q_row_t seq_q(input int k, input int mul, input int stride, input int m, input int add);
    q_row_t r;
    for (int i = 0; i < LANES; i++) r[i] = 8'(m * (k * mul + i * stride) + add);
    return r;
  endfunction

  // Single row from a fresh tile: checks the 3-cycle latency and the value.
  task automatic run_one(input string tag, input acc_row_t c, input q_row_t exp);
    do_reset();
    io.in_valid = 1'b1; io.c_in = c;
    step();
    io.in_valid = 1'b0;
    chk({tag, "_vld_c1"}, io.out_valid, 0);
    step();
    chk({tag, "_vld_c2"}, io.out_valid, 0);
    step();
    chk({tag, "_vld_c3"}, io.out_valid, 1);
    chk({tag, "_q"}, io.q_out, exp);
    chk({tag, "_last"}, io.out_last, 0);
    step();
    chk({tag, "_drain"}, io.out_valid, 0);
  endtask

  initial begin
    q_row_t expq[$];
    q_row_t held;
    logic   stall_prev;
    int     sent, got;

    io.in_valid = 1'b0; io.out_ready = 1'b1; io.c_in = '0;
    step(); step();
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_q_out", io.q_out, 0);
    chk("rst_out_last", io.out_last, 0);
    chk("rst_in_ready", io.in_ready, 1);

    scale = 16'sd1; shift = 6'd0; zero_point = 8'sd0; relu_en = 1'b0;
    run_one("sat", mk_acc(100, 300, -300, 0, 127, 128, -128, -129),
                   mk_q(100, 127, -128, 0, 127, 127, -128, -128));

    scale = 16'sd3; shift = 6'd2;
    run_one("round", mk_acc(10, 9, -10, -9, 0, 2, -2, 1),
                     mk_q(8, 7, -7, -7, 0, 2, -1, 1));

    scale = 16'sh8000; shift = 6'd63;
    run_one("shift_max", mk_acc(32'sh80000000, 32'sh7fffffff, -1073741824, 32'sh80000001, 0, 0, 0, 0),
                         mk_q(1, 0, 0, 0, 0, 0, 0, 0));

    scale = 16'sd1; shift = 6'd0; zero_point = 8'sd5; relu_en = 1'b1;
    run_one("relu", mk_acc(-5, 3, 200, -128, 122, 123, 0, -6),
                    mk_q(5, 8, 127, 5, 127, 127, 5, 5));

    shift = 6'd1; zero_point = -8'sd3; relu_en = 1'b0;
    run_one("zp_neg", mk_acc(5, -5, -251, -249, 261, 259, 0, 1),
                      mk_q(0, -5, -128, -127, 127, 127, -3, -2));

    // 16 back-to-back rows; config switched at row 4 lands on row 8.
    scale = 16'sd1; shift = 6'd0; zero_point = 8'sd0; relu_en = 1'b0;
    do_reset();
    for (int t = 0; t < 18; t++) begin
      if (t == 4) begin scale = 16'sd2; zero_point = 8'sd1; end
      io.in_valid = (t < 16);
      io.c_in = seq_acc(t, 1, 1);
      #1;
      chk("b2b_in_ready", io.in_ready, 1);
      step();
      if (t >= 2) begin
        chk("b2b_vld", io.out_valid, 1);
        chk("b2b_q", io.q_out, (t - 2 < 8) ? seq_q(t - 2, 1, 1, 1, 0) : seq_q(t - 2, 1, 1, 2, 1));
        chk("b2b_last", io.out_last, 64'((t - 2 == 7) || (t - 2 == 15)));
      end
    end
    io.in_valid = 1'b0;
    step();
    chk("b2b_idle", io.out_valid, 0);

    // Downstream stall of 5 cycles in the middle of a 10-row stream.
    scale = 16'sd1; zero_point = 8'sd0;
    do_reset();
    sent = 0; got = 0; stall_prev = 1'b0; held = '0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      io.out_ready = !(cyc >= 6 && cyc < 11);
      io.in_valid  = (sent < 10);
      io.c_in      = seq_acc(sent, 3, -7);
      #1;
      if (io.out_valid && !io.out_ready) begin
        chk("stall_in_ready", io.in_ready, 0);
        if (stall_prev) chk("stall_hold", io.q_out, held);
        held = io.q_out;
        stall_prev = 1'b1;
      end else begin
        stall_prev = 1'b0;
      end
      if (io.in_valid && io.in_ready) begin
        expq.push_back(seq_q(sent, 3, -7, 1, 0));
        sent++;
      end
      if (io.out_valid && io.out_ready) begin
        chk("stall_have_exp", 64'(expq.size() != 0), 1);
        if (expq.size() != 0) chk("stall_q", io.q_out, expq.pop_front());
        got++;
      end
      step();
    end
    chk("stall_sent", 64'(sent), 10);
    chk("stall_got", 64'(got), 10);

    // Reset with three rows in flight, then a fresh tile with new config.
    scale = 16'sd1;
    do_reset();
    io.out_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      io.in_valid = 1'b1; io.c_in = seq_acc(t, 1, 1);
      step();
    end
    chk("mid_pre_vld", io.out_valid, 1);
    rst = 1'b0; io.in_valid = 1'b0;
    step();
    chk("mid_rst_vld", io.out_valid, 0);
    chk("mid_rst_q", io.q_out, 0);
    chk("mid_rst_last", io.out_last, 0);
    rst = 1'b1; io.out_ready = 1'b1; scale = 16'sd2;
    for (int t = 0; t < 10; t++) begin
      io.in_valid = (t < 8);
      io.c_in = seq_acc(t, 1, 1);
      step();
      if (t >= 2) begin
        chk("mid_new_vld", io.out_valid, 1);
        chk("mid_new_q", io.q_out, seq_q(t - 2, 1, 1, 2, 0));
        chk("mid_new_last", io.out_last, 64'(t - 2 == 7));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
